// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display: double-buffered
// value, per-digit slot timing, leading-zero blanking, DP control and PWM brightness.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    input  logic [NUM_DIGITS-1:0]     load_dp,
    input  logic                      lz_en,
    input  logic [2:0]                bright,
    output logic [3:0]                bcd_out,
    output logic [NUM_DIGITS-1:0]     dig_sel_n,
    output logic                      dp_n,
    output logic                      frame_tick
);

    localparam int CW      = $clog2(SLOT_CYCLES);
    localparam int SUB_LEN = SLOT_CYCLES / 8;
    localparam int SW      = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
    localparam int DW      = $clog2(NUM_DIGITS);

    logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
    logic [SW-1:0]           sub_cnt_q, sub_cnt_d;
    logic [2:0]              phase_q, phase_d;
    logic [DW-1:0]           dig_idx_q, dig_idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, pend_q;
    logic [NUM_DIGITS-1:0]   active_dp_q, pend_dp_q;
    logic                    pend_full_q, pend_full_d;
    logic                    lz_q;
    logic [2:0]              bright_q;
    logic                    frame_tick_q;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   sel_n_q, sel_n_d;
    logic                    dp_n_q, dp_n_d;

    logic slot_last, sub_last, dig_last, frame_end, accept, commit;
    logic slot_start, all_zero, blank, dp_bit, on_phase, lit;
    logic [3:0] nib;

    always_comb begin
        slot_last  = (slot_cnt_q == CW'(SLOT_CYCLES - 1));
        sub_last   = (sub_cnt_q == SW'(SUB_LEN - 1));
        dig_last   = (dig_idx_q == DW'(NUM_DIGITS - 1));
        slot_start = (slot_cnt_q == '0);
        frame_end  = slot_last && dig_last;
        accept     = load_valid && !pend_full_q;
        commit     = frame_end && pend_full_q;

        slot_cnt_d = slot_last ? '0 : slot_cnt_q + CW'(1);
        sub_cnt_d  = sub_last ? '0 : sub_cnt_q + SW'(1);
        phase_d    = slot_last ? 3'd0 : (sub_last ? phase_q + 3'd1 : phase_q);
        dig_idx_d  = dig_idx_q;
        if (slot_last)
            dig_idx_d = dig_last ? '0 : dig_idx_q + DW'(1);

        pend_full_d = pend_full_q;
        if (commit)
            pend_full_d = 1'b0;
        else if (accept)
            pend_full_d = 1'b1;
    end

    // Per-digit display decision from the current scan state; registered below.
    always_comb begin
        nib      = active_q[4*int'(dig_idx_q) +: 4];
        dp_bit   = active_dp_q[dig_idx_q];
        all_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(dig_idx_q) && active_q[4*i +: 4] != 4'd0)
                all_zero = 1'b0;
        end
        blank    = lz_q && (dig_idx_q != '0) && all_zero;
        // Sub-phase 0 is dead time; bright=7 saturates at sub-phase 7.
        on_phase = (phase_q != 3'd0) && ({1'b0, phase_q} <= ({1'b0, bright_q} + 4'd1));
        lit      = on_phase && (!blank || dp_bit);
        sel_n_d  = lit ? ~(NUM_DIGITS'(1) << dig_idx_q) : '1;
        bcd_d    = blank ? 4'd0 : nib;
        dp_n_d   = !(on_phase && dp_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            sub_cnt_q    <= '0;
            phase_q      <= 3'd0;
            dig_idx_q    <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            lz_q         <= 1'b0;
            bright_q     <= 3'd0;
            frame_tick_q <= 1'b0;
            bcd_q        <= 4'd0;
            sel_n_q      <= '1;
            dp_n_q       <= 1'b1;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            phase_q      <= phase_d;
            dig_idx_q    <= dig_idx_d;
            pend_full_q  <= pend_full_d;
            frame_tick_q <= commit;
            bcd_q        <= bcd_d;
            sel_n_q      <= sel_n_d;
            dp_n_q       <= dp_n_d;
            if (slot_start) begin
                lz_q     <= lz_en;
                bright_q <= bright;
            end
            if (accept) begin
                pend_q    <= load_data;
                pend_dp_q <= load_dp;
            end
            if (commit) begin
                active_q    <= pend_q;
                active_dp_q <= pend_dp_q;
            end
        end
    end

    assign load_ready = !pend_full_q;
    assign bcd_out    = bcd_q;
    assign dig_sel_n  = sel_n_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule
